eth_rx_packet_writer: RTL

- Ingress stage directly upstream of the Ethernet packet buffer write port.
- Accepts the MAC RX byte-lane stream (data/keep/last/error, valid-ready) and writes each frame into the current buffer write slot.
- Splits the partial final beat into naturally aligned 4/2/1-byte writes, then commits the frame length and reserves the slot.
- Drops frames that are errored, oversized, malformed, or arrive when no slot is free, and counts them.

---
 rtl/eth_rx_packet_writer.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_packet_writer.sv
// eth_rx_packet_writer
// Ingress stage in front of the packet buffer write port. Takes the MAC RX
// byte-lane stream, writes each frame into the current buffer slot, splits a
// partial final beat into naturally aligned 4/2/1-byte writes, then commits the
// frame length and reserves the slot. Errored, oversized, malformed or
// slot-less frames are discarded and counted.
module eth_rx_packet_writer #(
    parameter int data_width_p = 64,
    parameter int els_p        = 2048,
    localparam int keep_width_lp        = data_width_p / 8,
    localparam int addr_width_lp        = $clog2(els_p),
    localparam int packet_size_width_lp = $clog2(els_p + 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,

    input  logic                            rx_valid_i,
    output logic                            rx_ready_o,
    input  logic [data_width_p-1:0]         rx_data_i,
    input  logic [keep_width_lp-1:0]        rx_keep_i,
    input  logic                            rx_last_i,
    input  logic                            rx_error_i,

    input  logic                            packet_req_i,
    output logic                            packet_send_o,
    output logic                            packet_wsize_valid_o,
    output logic [packet_size_width_lp-1:0] packet_wsize_o,
    output logic                            packet_wvalid_o,
    output logic [addr_width_lp-1:0]        packet_waddr_o,
    output logic [data_width_p-1:0]         packet_wdata_o,
    output logic [1:0]                      packet_wdata_size_o,

    output logic                            packet_dropped_o,
    output logic [15:0]                     drop_count_o
);

    // Width of a byte count within one beat (0..keep_width_lp).
    localparam int cnt_width_lp = $clog2(keep_width_lp + 1);
    // One extra bit so the overflow compare cannot wrap.
    localparam int ext_width_lp = packet_size_width_lp + 1;

    typedef enum logic [1:0] {
        RECV   = 2'd0,
        SPLIT  = 2'd1,
        COMMIT = 2'd2,
        DROP   = 2'd3
    } state_e;

    function automatic logic [cnt_width_lp-1:0] popcount(input logic [keep_width_lp-1:0] v);
        logic [cnt_width_lp-1:0] n;
        n = '0;
        for (int i = 0; i < keep_width_lp; i++) begin
            n = n + cnt_width_lp'(v[i]);
        end
        return n;
    endfunction

    // Index of the most significant set bit: log2 of the largest power of two
    // not exceeding v, which is the next chunk of a descending decomposition.
    function automatic logic [1:0] msb_index(input logic [cnt_width_lp-1:0] v);
        logic [1:0] r;
        r = '0;
        for (int i = 0; i < cnt_width_lp; i++) begin
            if (v[i]) begin
                r = 2'(i);
            end
        end
        return r;
    endfunction

    state_e                          state_r, state_n;
    logic [packet_size_width_lp-1:0] off_r, off_n;
    logic                            start_r, start_n;
    logic [cnt_width_lp-1:0]         rem_r, rem_n;
    logic [15:0]                     drop_count_r;
    logic                            drop_evt;

    logic [cnt_width_lp-1:0]         keep_cnt;
    logic                            keep_full;
    logic                            keep_contig;
    logic                            too_long;
    logic                            bad_beat;
    logic [cnt_width_lp-1:0]         cur_bytes;
    logic [1:0]                      chunk_log2;
    logic [cnt_width_lp-1:0]         chunk_bytes;
    logic [packet_size_width_lp-1:0] chunk_ext;
    logic                            final_chunk;

    // Beat classification and the chunk to be written this cycle.
    always_comb begin
        keep_cnt    = popcount(rx_keep_i);
        keep_full   = &rx_keep_i;
        // Contiguous from lane 0 means keep+1 is a power of two (or wraps to 0).
        keep_contig = ((rx_keep_i & (rx_keep_i + keep_width_lp'(1))) == '0);
        too_long    = (ext_width_lp'(off_r) + ext_width_lp'(keep_cnt)) > ext_width_lp'(els_p);
        bad_beat    = (start_r && !packet_req_i)
                   || !keep_contig
                   || (!rx_last_i && !keep_full)
                   || (rx_last_i && (rx_keep_i == '0))
                   || too_long;
        cur_bytes   = (state_r == SPLIT) ? rem_r : keep_cnt;
        chunk_log2  = msb_index(cur_bytes);
        chunk_bytes = cnt_width_lp'(1) << chunk_log2;
        chunk_ext   = packet_size_width_lp'(chunk_bytes);
        final_chunk = (cur_bytes == chunk_bytes);
    end

    // Next-state, handshake and write strobes; everything is held at 0 in reset.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_n              = state_r;
        off_n                = off_r;
        start_n              = start_r;
        rem_n                = rem_r;
        drop_evt             = 1'b0;
        rx_ready_o           = 1'b0;
        packet_wvalid_o      = 1'b0;
        packet_send_o        = 1'b0;
        packet_wsize_valid_o = 1'b0;

        if (!reset_i) begin
            unique case (state_r)
                RECV: begin
                    if (rx_valid_i) begin
                        if (bad_beat) begin
                            rx_ready_o = 1'b1;
                            drop_evt   = 1'b1;
                            off_n      = '0;
                            start_n    = 1'b1;
                            state_n    = rx_last_i ? RECV : DROP;
                        end else begin
                            packet_wvalid_o = 1'b1;
                            off_n           = off_r + chunk_ext;
                            start_n         = 1'b0;
                            if (!rx_last_i) begin
                                rx_ready_o = 1'b1;
                            end else if (final_chunk) begin
                                rx_ready_o = 1'b1;
                                if (rx_error_i) begin
                                    drop_evt = 1'b1;
                                    off_n    = '0;
                                    start_n  = 1'b1;
                                    state_n  = RECV;
                                end else begin
                                    state_n = COMMIT;
                                end
                            end else begin
                                rem_n   = keep_cnt - chunk_bytes;
                                state_n = SPLIT;
                            end
                        end
                    end
                end
                SPLIT: begin
                    if (rx_valid_i) begin
                        packet_wvalid_o = 1'b1;
                        off_n           = off_r + chunk_ext;
                        rem_n           = rem_r - chunk_bytes;
                        if (final_chunk) begin
                            rx_ready_o = 1'b1;
                            if (rx_error_i) begin
                                drop_evt = 1'b1;
                                off_n    = '0;
                                start_n  = 1'b1;
                                state_n  = RECV;
                            end else begin
                                state_n = COMMIT;
                            end
                        end
                    end
                end
                COMMIT: begin
                    packet_wsize_valid_o = 1'b1;
                    packet_send_o        = 1'b1;
                    off_n                = '0;
                    start_n              = 1'b1;
                    state_n              = RECV;
                end
                DROP: begin
                    rx_ready_o = 1'b1;
                    if (rx_valid_i && rx_last_i) begin
                        start_n = 1'b1;
                        state_n = RECV;
                    end
                end
                default: state_n = RECV;
            endcase
        end
    end

    // FSM state, byte offset and split remainder.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset_i) begin
            state_r <= RECV;
            off_r   <= '0;
            start_r <= 1'b1;
            rem_r   <= '0;
        end else begin
            state_r <= state_n;
            off_r   <= off_n;
            start_r <= start_n;
            rem_r   <= rem_n;
        end
    end

    // Saturating dropped-frame counter.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            drop_count_r <= '0;
        end else if (drop_evt && (drop_count_r != 16'hFFFF)) begin
            drop_count_r <= drop_count_r + 16'd1;
        end
    end

    assign packet_wsize_o      = off_r;
    assign packet_waddr_o      = off_r[addr_width_lp-1:0];
    assign packet_wdata_o      = rx_data_i;
    assign packet_wdata_size_o = chunk_log2;
    assign packet_dropped_o    = drop_evt;
    assign drop_count_o        = drop_count_r;

endmodule
